// File: rtl/snake_body.sv
// Snake movement/body stage: holds segment coordinates, steps on move_tick,
// grows on food, detects wall/self collisions and answers renderer cell queries.
module snake_body #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int X_W      = 5,
    parameter int Y_W      = 5,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int L_W      = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           move_tick,
    input  logic           start,
    input  logic [1:0]     dir,
    input  logic [X_W-1:0] food_x,
    input  logic [Y_W-1:0] food_y,
    input  logic           food_valid,
    input  logic [X_W-1:0] query_x,
    input  logic [Y_W-1:0] query_y,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [L_W-1:0] length,
    output logic           ate,
    output logic           game_over,
    output logic           hit_head,
    output logic           hit_body,
    output logic [1:0]     state_dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    localparam logic [X_W-1:0] X_MAX    = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX    = Y_W'(GRID_H - 1);
    localparam logic [L_W-1:0] LEN_MAX  = L_W'(MAX_LEN);
    localparam logic [L_W-1:0] LEN_INIT = L_W'(INIT_LEN);

    logic [1:0]     state_q, state_d;
    logic [L_W-1:0] len_q, len_d;
    logic           ate_q, ate_d;
    logic           hit_head_q, hit_body_q;
    logic [X_W-1:0] seg_x_q [MAX_LEN];
    logic [Y_W-1:0] seg_y_q [MAX_LEN];

    logic [X_W-1:0] nh_x;
    logic [Y_W-1:0] nh_y;
    logic           wall;
    logic           eat;
    logic           grow;
    logic           self_hit;
    logic [L_W-1:0] self_lim;
    logic           step;
    logic           do_move;
    logic           q_head;
    logic           q_body;

    // Next head position and wall check for the current direction.
    always_comb begin
        nh_x = seg_x_q[0];
        nh_y = seg_y_q[0];
        wall = 1'b0;
        case (dir)
            DIR_RIGHT: begin
                nh_x = seg_x_q[0] + X_W'(1);
                wall = (seg_x_q[0] == X_MAX);
            end
            DIR_LEFT: begin
                nh_x = seg_x_q[0] - X_W'(1);
                wall = (seg_x_q[0] == '0);
            end
            DIR_DOWN: begin
                nh_y = seg_y_q[0] + Y_W'(1);
                wall = (seg_y_q[0] == Y_MAX);
            end
            DIR_UP: begin
                nh_y = seg_y_q[0] - Y_W'(1);
                wall = (seg_y_q[0] == '0);
            end
            default: begin
                nh_x = seg_x_q[0];
                nh_y = seg_y_q[0];
                wall = 1'b0;
            end
        endcase
    end

    assign eat  = food_valid && (nh_x == food_x) && (nh_y == food_y);
    assign grow = eat && (len_q < LEN_MAX);

    // When not growing the tail vacates its cell this step, so it is excluded.
    always_comb begin
        self_lim = grow ? len_q : (len_q - L_W'(1));
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((L_W'(i) < self_lim) && (seg_x_q[i] == nh_x) && (seg_y_q[i] == nh_y)) begin
                self_hit = 1'b1;
            end
        end
    end

    assign step    = (state_q == ST_RUN) && move_tick;
    assign do_move = step && !wall && !self_hit;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ate_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (step && (wall || self_hit)) begin
                    state_d = ST_DEAD;
                end else if (do_move) begin
                    ate_d = eat;
                    if (grow) begin
                        len_d = len_q + L_W'(1);
                    end
                end
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= LEN_INIT;
            ate_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ate_q   <= ate_d;
        end
    end

    // A full shift also keeps the old tail in place as the new last segment on growth.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    seg_x_q[i] <= X_W'(GRID_W / 2 - i);
                    seg_y_q[i] <= Y_W'(GRID_H / 2);
                end else begin
                    seg_x_q[i] <= '0;
                    seg_y_q[i] <= '0;
                end
            end
        end else if (do_move) begin
            for (int i = MAX_LEN - 1; i >= 1; i--) begin
                seg_x_q[i] <= seg_x_q[i-1];
                seg_y_q[i] <= seg_y_q[i-1];
            end
            seg_x_q[0] <= nh_x;
            seg_y_q[0] <= nh_y;
        end
    end

    always_comb begin
        q_head = (seg_x_q[0] == query_x) && (seg_y_q[0] == query_y);
        q_body = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((L_W'(i) < len_q) && (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y)) begin
                q_body = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_head_q <= 1'b0;
            hit_body_q <= 1'b0;
        end else begin
            hit_head_q <= q_head;
            hit_body_q <= q_body && !q_head;
        end
    end

    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign length    = len_q;
    assign ate       = ate_q;
    assign game_over = (state_q == ST_DEAD);
    assign hit_head  = hit_head_q;
    assign hit_body  = hit_body_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: default build plus INIT_LEN=5/4 and MAX_LEN=4 builds.
module tb_snake_body;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Default-parameter instance.
    logic       a_tick, a_start, a_fv;
    logic [1:0] a_dir;
    logic [4:0] a_fx, a_fy, a_qx, a_qy;
    logic [4:0] a_hx, a_hy, a_len;
    logic       a_ate, a_go, a_hh, a_hb;
    logic [1:0] a_st;

    // Shared stimulus for the INIT_LEN=5 and INIT_LEN=4 instances.
    logic       bc_tick, bc_start, bc_fv;
    logic [1:0] bc_dir;
    logic [4:0] bc_fx, bc_fy, bc_qx, bc_qy;
    logic [4:0] b_hx, b_hy, b_len, c_hx, c_hy, c_len;
    logic       b_ate, b_go, b_hh, b_hb, c_ate, c_go, c_hh, c_hb;
    logic [1:0] b_st, c_st;

    // MAX_LEN=4 instance.
    logic       d_tick, d_start, d_fv;
    logic [1:0] d_dir;
    logic [4:0] d_fx, d_fy, d_qx, d_qy;
    logic [4:0] d_hx, d_hy, d_len;
    logic       d_ate, d_go, d_hh, d_hb;
    logic [1:0] d_st;

    snake_body dut_a (
        .clk(clk), .rst(rst), .move_tick(a_tick), .start(a_start), .dir(a_dir),
        .food_x(a_fx), .food_y(a_fy), .food_valid(a_fv), .query_x(a_qx), .query_y(a_qy),
        .head_x(a_hx), .head_y(a_hy), .length(a_len), .ate(a_ate), .game_over(a_go),
        .hit_head(a_hh), .hit_body(a_hb), .state_dbg(a_st)
    );

    snake_body #(.INIT_LEN(5)) dut_b (
        .clk(clk), .rst(rst), .move_tick(bc_tick), .start(bc_start), .dir(bc_dir),
        .food_x(bc_fx), .food_y(bc_fy), .food_valid(bc_fv), .query_x(bc_qx), .query_y(bc_qy),
        .head_x(b_hx), .head_y(b_hy), .length(b_len), .ate(b_ate), .game_over(b_go),
        .hit_head(b_hh), .hit_body(b_hb), .state_dbg(b_st)
    );

    snake_body #(.INIT_LEN(4)) dut_c (
        .clk(clk), .rst(rst), .move_tick(bc_tick), .start(bc_start), .dir(bc_dir),
        .food_x(bc_fx), .food_y(bc_fy), .food_valid(bc_fv), .query_x(bc_qx), .query_y(bc_qy),
        .head_x(c_hx), .head_y(c_hy), .length(c_len), .ate(c_ate), .game_over(c_go),
        .hit_head(c_hh), .hit_body(c_hb), .state_dbg(c_st)
    );

    snake_body #(.MAX_LEN(4), .INIT_LEN(3)) dut_d (
        .clk(clk), .rst(rst), .move_tick(d_tick), .start(d_start), .dir(d_dir),
        .food_x(d_fx), .food_y(d_fy), .food_valid(d_fv), .query_x(d_qx), .query_y(d_qy),
        .head_x(d_hx), .head_y(d_hy), .length(d_len), .ate(d_ate), .game_over(d_go),
        .hit_head(d_hh), .hit_body(d_hb), .state_dbg(d_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic [1:0] d);
        @(negedge clk);
        a_dir  = d;
        a_tick = 1'b1;
        @(negedge clk);
        a_tick = 1'b0;
    endtask

    task automatic step_bc(input logic [1:0] d);
        @(negedge clk);
        bc_dir  = d;
        bc_tick = 1'b1;
        @(negedge clk);
        bc_tick = 1'b0;
    endtask

    task automatic step_d(input logic [1:0] d);
        @(negedge clk);
        d_dir  = d;
        d_tick = 1'b1;
        @(negedge clk);
        d_tick = 1'b0;
    endtask

    task automatic query_a(input logic [4:0] x, input logic [4:0] y);
        a_qx = x;
        a_qy = y;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        a_tick = 0; a_start = 0; a_fv = 0; a_dir = 0; a_fx = 0; a_fy = 0; a_qx = 0; a_qy = 0;
        bc_tick = 0; bc_start = 0; bc_fv = 0; bc_dir = 0; bc_fx = 0; bc_fy = 0; bc_qx = 0; bc_qy = 0;
        d_tick = 0; d_start = 0; d_fv = 0; d_dir = 0; d_fx = 0; d_fy = 0; d_qx = 0; d_qy = 0;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_head_x", a_hx, 16);
        check("rst_head_y", a_hy, 12);
        check("rst_len", a_len, 3);
        check("rst_ate", a_ate, 0);
        check("rst_game_over", a_go, 0);
        check("rst_hit_head", a_hh, 0);
        check("rst_hit_body", a_hb, 0);
        check("rst_state", a_st, 0);
        rst = 1'b0;

        // IDLE: tick ignored, queries live.
        step_a(2'b00);
        check("idle_head_x", a_hx, 16);
        query_a(5'd15, 5'd12);
        check("idle_q15_body", a_hb, 1);
        check("idle_q15_head", a_hh, 0);
        query_a(5'd16, 5'd12);
        check("idle_q16_head", a_hh, 1);
        check("idle_q16_body", a_hb, 0);
        query_a(5'd0, 5'd0);
        check("idle_q00_head", a_hh, 0);
        check("idle_q00_body", a_hb, 0);

        // Start together with a tick: the tick is ignored.
        @(negedge clk);
        a_start = 1'b1;
        a_tick  = 1'b1;
        a_dir   = 2'b00;
        @(negedge clk);
        a_tick = 1'b0;
        check("start_state", a_st, 1);
        check("start_tick_ignored", a_hx, 16);

        // First step to the right.
        step_a(2'b00);
        check("step1_head_x", a_hx, 17);
        check("step1_head_y", a_hy, 12);
        check("step1_len", a_len, 3);
        check("step1_ate", a_ate, 0);
        query_a(5'd16, 5'd12);
        check("step1_seg1", a_hb, 1);
        query_a(5'd15, 5'd12);
        check("step1_seg2", a_hb, 1);
        query_a(5'd14, 5'd12);
        check("step1_old_tail_gone", a_hb, 0);
        query_a(5'd17, 5'd12);
        check("step1_q_head", a_hh, 1);

        // Eat food ahead: grow with tail kept.
        a_fx = 5'd18;
        a_fy = 5'd12;
        a_fv = 1'b1;
        step_a(2'b00);
        check("eat_head_x", a_hx, 18);
        check("eat_len", a_len, 4);
        check("eat_ate_pulse", a_ate, 1);
        a_fv = 1'b0;
        query_a(5'd15, 5'd12);
        check("eat_ate_clears", a_ate, 0);
        check("eat_tail_kept", a_hb, 1);

        // Walk to (31,5): 7 up, then 13 right.
        for (int i = 0; i < 7; i++) step_a(2'b11);
        for (int i = 0; i < 13; i++) step_a(2'b00);
        check("edge_head_x", a_hx, 31);
        check("edge_head_y", a_hy, 5);
        check("edge_alive", a_go, 0);

        // Wall collision to the right.
        step_a(2'b00);
        check("wall_game_over", a_go, 1);
        check("wall_head_x", a_hx, 31);
        check("wall_len", a_len, 4);
        check("wall_ate", a_ate, 0);
        step_a(2'b10);
        step_a(2'b11);
        check("dead_head_x", a_hx, 31);
        check("dead_head_y", a_hy, 5);
        check("dead_len", a_len, 4);
        query_a(5'd31, 5'd5);
        check("dead_q_head", a_hh, 1);

        // Reset with a simultaneous tick restores reset state.
        @(negedge clk);
        rst    = 1'b1;
        a_tick = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        a_tick = 1'b0;
        check("rerst_head_x", a_hx, 16);
        check("rerst_head_y", a_hy, 12);
        check("rerst_game_over", a_go, 0);
        check("rerst_len", a_len, 3);
        check("rerst_state", a_st, 0);

        // Self collision (INIT_LEN=5) versus moving into the tail (INIT_LEN=4).
        @(negedge clk);
        bc_start = 1'b1;
        @(negedge clk);
        step_bc(2'b00);
        step_bc(2'b10);
        step_bc(2'b01);
        check("self5_alive_before", b_go, 0);
        check("self5_head_x_before", b_hx, 16);
        check("self5_head_y_before", b_hy, 13);
        step_bc(2'b11);
        check("self5_game_over", b_go, 1);
        check("self5_head_x", b_hx, 16);
        check("self5_head_y", b_hy, 13);
        check("self5_len", b_len, 5);
        check("tail4_alive", c_go, 0);
        check("tail4_head_x", c_hx, 16);
        check("tail4_head_y", c_hy, 12);
        check("tail4_len", c_len, 4);

        // Growth saturates at MAX_LEN=4; ate still pulses.
        @(negedge clk);
        d_start = 1'b1;
        @(negedge clk);
        d_fx = 5'd17;
        d_fy = 5'd12;
        d_fv = 1'b1;
        step_d(2'b00);
        check("max_eat1_len", d_len, 4);
        check("max_eat1_ate", d_ate, 1);
        d_fx = 5'd18;
        step_d(2'b00);
        check("max_eat2_len", d_len, 4);
        check("max_eat2_ate", d_ate, 1);
        check("max_eat2_head_x", d_hx, 18);
        d_fv = 1'b0;
        @(negedge clk);
        check("max_ate_clears", d_ate, 0);
        check("max_alive", d_go, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Movement/body stage directly downstream of the direction-control block.
- Consumes the 2-bit direction, start flag and move tick, and keeps the snake's segment coordinates in a register array.
- Grows the snake on food, and detects wall and self collisions.
- Exposes a registered pixel-cell query port for the VGA renderer, plus head/length/ate/game_over status for the food and score logic.

Parameters:
- GRID_W, 32, grid width in cells; x counts 0..GRID_W-1 left to right.
- GRID_H, 24, grid height in cells; y counts 0..GRID_H-1 top to bottom.
- X_W, 5, x coordinate width.
- Y_W, 5, y coordinate width.
- MAX_LEN, 16, segment capacity.
- INIT_LEN, 3, length after reset; 2 <= INIT_LEN <= MAX_LEN, INIT_LEN <= GRID_W/2.
- L_W, 5, length counter width; must hold MAX_LEN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- move_tick  in  1  one-cycle movement pulse; the same pulse that drives the direction block
- start  in  1  level; high once the player has pressed a turn
- dir  in  2  00 right, 01 left, 10 down, 11 up; stable on move_tick
- food_x  in  X_W  food cell x
- food_y  in  Y_W  food cell y
- food_valid  in  1  food present
- query_x  in  X_W  renderer cell x
- query_y  in  Y_W  renderer cell y
- head_x  out  X_W  current head x
- head_y  out  Y_W  current head y
- length  out  L_W  current segment count
- ate  out  1  one-cycle pulse when food is consumed
- game_over  out  1  sticky collision flag
- hit_head  out  1  query cell equals head; 1-cycle latency
- hit_body  out  1  query cell equals a non-head segment; 1-cycle latency

Behaviour:
- Segments: seg[0] is the head, seg[length-1] the tail. Entries at index >= length are don't-care and never match.
- Reset state:
  - state=IDLE, length=INIT_LEN.
  - seg[i] = (GRID_W/2 - i, GRID_H/2) for i < INIT_LEN, so the snake faces right, matching the direction block's reset.
  - ate=0, game_over=0, hit_head=0, hit_body=0.
- FSM states: IDLE, RUN, DEAD.
  - IDLE -> RUN on any cycle with start=1. A move_tick in that same cycle is ignored; all ticks are ignored in IDLE.
  - RUN: every move_tick runs one step, described below. No change between ticks.
  - DEAD: game_over=1. Segments and length are frozen; ticks are ignored. Only rst leaves DEAD.
- Step, evaluated combinationally from the current registers and applied at the tick edge:
  - Next head nh = seg[0] + 1 in x for right, -1 in x for left, +1 in y for down, -1 in y for up.
  - Wall: dir right with x==GRID_W-1, left with x==0, down with y==GRID_H-1, or up with y==0. Collision; there is no wrap-around.
  - eat = food_valid and nh==(food_x,food_y).
  - grow = eat and length < MAX_LEN.
  - Self: nh equals seg[i] for some i < length-1 (no growth) or i < length (growth). The tail cell is legal when not growing because the tail vacates it.
  - A reversed dir is not filtered here; it collides with seg[1].
  - On collision: no shift, length unchanged, ate=0, state -> DEAD, game_over=1 from the next cycle.
  - Otherwise: seg[i] <= seg[i-1] for i >= 1, and seg[0] <= nh.
    - If grow, length <= length+1; the old tail is kept as the new last segment.
    - If eat at MAX_LEN: move without growth; ate still pulses.
  - ate is high for exactly the cycle after the tick edge.
- head_x/head_y are seg[0] directly, updated the cycle after the tick.
- Query: a registered compare over all segments. hit_head and hit_body reflect query_x/query_y sampled one cycle earlier, are mutually exclusive, and stay valid in IDLE and DEAD.
- rst mid-run or in DEAD: restores the full reset state on the next edge. rst overrides a simultaneous move_tick.

Test Plan:
- Reset, start=1, one tick with dir=00 -> head (17,12), seg[1..2] = (16,12),(15,12), length 3, ate 0.
- Food at (18,12), food_valid=1, tick with dir=00 from head (17,12) -> head (18,12), length 4, ate high exactly one cycle, tail cell retained.
- Head (31,5), dir=00, tick -> game_over=1 next cycle. Further ticks leave head (31,5) and length unchanged. rst -> head (16,12), game_over 0.
- INIT_LEN=5, ticks with dir 00, 10, 01, 11 -> collision on the 4th tick (nh (16,12) equals seg[3]), DEAD. Variant with INIT_LEN=4: the same nh is the tail, so no collision and the move proceeds.
- MAX_LEN=4, INIT_LEN=3: eat twice -> length 4 and then stays 4; ate pulses both times.
- Tick with start=0 -> no movement. query (15,12) -> hit_body=1 one cycle later. query (16,12) -> hit_head=1. query (0,0) -> both 0.
